// File: rtl/hazard_ctrl.sv
// Hazard and stall controller for a 5-stage pipeline without forwarding.
// Tracks in-flight register writes (EX/MEM/WB) and drives PC, IF/ID and ID/EX controls.
module hazard_ctrl #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              id_valid_i,
    input  logic [REG_AW-1:0] id_rs1_i,
    input  logic [REG_AW-1:0] id_rs2_i,
    input  logic              id_rs1_used_i,
    input  logic              id_rs2_used_i,
    input  logic [REG_AW-1:0] id_rd_i,
    input  logic              id_rd_wen_i,
    input  logic              br_taken_i,
    input  logic              mem_ready_i,
    output logic              pc_hold_o,
    output logic              if_id_hold_o,
    output logic              if_id_flush_o,
    output logic              id_ex_flush_o,
    output logic              pipe_freeze_o,
    output logic              raw_stall_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    logic              ex_v, mem_v, wb_v;
    logic [REG_AW-1:0] ex_rd, mem_rd, wb_rd;
    logic [CNT_W-1:0]  cnt;

    logic hit1, hit2, raw, freeze, branch, raw_stall, new_v;

    // No register-file bypass, so a destination stays pending through WB.
    assign hit1 = id_rs1_used_i && (id_rs1_i != '0) &&
                  ((ex_v && ex_rd == id_rs1_i) || (mem_v && mem_rd == id_rs1_i) ||
                   (wb_v && wb_rd == id_rs1_i));
    assign hit2 = id_rs2_used_i && (id_rs2_i != '0) &&
                  ((ex_v && ex_rd == id_rs2_i) || (mem_v && mem_rd == id_rs2_i) ||
                   (wb_v && wb_rd == id_rs2_i));

    assign raw       = id_valid_i && (hit1 || hit2);
    assign freeze    = !mem_ready_i;
    assign branch    = mem_ready_i && br_taken_i;
    assign raw_stall = mem_ready_i && !br_taken_i && raw;
    assign new_v     = id_valid_i && id_rd_wen_i && (id_rd_i != '0);

    assign pc_hold_o     = freeze || raw_stall;
    assign if_id_hold_o  = freeze || raw_stall;
    assign if_id_flush_o = branch;
    assign id_ex_flush_o = branch || raw_stall;
    assign pipe_freeze_o = freeze;
    assign raw_stall_o   = raw_stall;
    assign stall_cnt_o   = cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ex_v   <= 1'b0;
            mem_v  <= 1'b0;
            wb_v   <= 1'b0;
            ex_rd  <= '0;
            mem_rd <= '0;
            wb_rd  <= '0;
            cnt    <= '0;
        end else if (!freeze) begin
            wb_v   <= mem_v;
            wb_rd  <= mem_rd;
            mem_v  <= ex_v;
            mem_rd <= ex_rd;
            // Branch kills and RAW stalls both push a bubble into EX.
            ex_v   <= new_v && !br_taken_i && !raw;
            ex_rd  <= id_rd_i;
            if (raw_stall && cnt != '1)
                cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: per-register busy-countdown model predicts the
// controls each cycle; a negedge monitor pops and compares.
module tb_hazard_ctrl;

    localparam int REG_AW = 5;
    localparam int CNT_W  = 4;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic id_valid = 1'b0, rs1_used = 1'b0, rs2_used = 1'b0, rd_wen = 1'b0;
    logic [REG_AW-1:0] rs1 = '0, rs2 = '0, rd = '0;
    logic br_taken = 1'b0, mem_ready = 1'b1;
    logic pc_hold, if_id_hold, if_id_flush, id_ex_flush, pipe_freeze, raw_stall;
    logic [CNT_W-1:0] stall_cnt;

    int checks = 0;
    int errors = 0;
    logic [9:0] exp_q[$];

    // Model: busy[r] = cycles of advance left until r is written back.
    int busy[32];
    int mcnt;

    hazard_ctrl #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .id_valid_i(id_valid), .id_rs1_i(rs1), .id_rs2_i(rs2),
        .id_rs1_used_i(rs1_used), .id_rs2_used_i(rs2_used),
        .id_rd_i(rd), .id_rd_wen_i(rd_wen),
        .br_taken_i(br_taken), .mem_ready_i(mem_ready),
        .pc_hold_o(pc_hold), .if_id_hold_o(if_id_hold), .if_id_flush_o(if_id_flush),
        .id_ex_flush_o(id_ex_flush), .pipe_freeze_o(pipe_freeze),
        .raw_stall_o(raw_stall), .stall_cnt_o(stall_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [9:0] actual();
        return {pc_hold, if_id_hold, if_id_flush, id_ex_flush, pipe_freeze, raw_stall, stall_cnt};
    endfunction

    function automatic bit model_raw();
        bit h1, h2;
        h1 = rs1_used && rs1 != 0 && busy[rs1] > 0;
        h2 = rs2_used && rs2 != 0 && busy[rs2] > 0;
        return id_valid && (h1 || h2);
    endfunction

    function automatic logic [9:0] expected();
        bit frz, br, rs;
        logic [CNT_W-1:0] c;
        frz = !mem_ready;
        br  = !frz && br_taken;
        rs  = !frz && !br && model_raw();
        c   = CNT_W'(mcnt);
        return {frz || rs, frz || rs, br, br || rs, frz, rs, c};
    endfunction

    task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %b want %b", name, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) busy[i] = 0;
        mcnt = 0;
    endtask

    task automatic model_edge();
        bit frz, br, rs;
        frz = !mem_ready;
        br  = !frz && br_taken;
        rs  = !frz && !br && model_raw();
        if (!frz) begin
            for (int i = 0; i < 32; i++) if (busy[i] > 0) busy[i]--;
            if (!br && !rs && id_valid && rd_wen && rd != 0) busy[rd] = 3;
            if (rs && mcnt < CMAX) mcnt++;
        end
    endtask

    // Present one cycle of inputs, queue the prediction, then advance past the edge.
    task automatic step(input bit v, input int a, input bit ua, input int b, input bit ub,
                        input int d, input bit w, input bit br, input bit mr);
        id_valid = v; rs1 = REG_AW'(a); rs1_used = ua; rs2 = REG_AW'(b); rs2_used = ub;
        rd = REG_AW'(d); rd_wen = w; br_taken = br; mem_ready = mr;
        exp_q.push_back(expected());
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0; id_valid = 0; br_taken = 0; mem_ready = 1;
        model_clear();
        #1 check("reset_ready", actual(), 10'b0);
        mem_ready = 1'b0;
        #1 check("reset_freeze", actual(), {5'b11001, 1'b0, 4'b0});
        mem_ready = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    // Hold the consumer in ID until the model says the hazard is gone.
    task automatic hold_consumer(input int a, input int b);
        for (int k = 0; k < 12; k++) begin
            if (!(mem_ready && model_raw()) && k > 0) break;
            step(1, a, 1, b, 1, 20, 1, 0, 1);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) check("cycle", actual(), exp_q.pop_front());
    end

    initial begin
        model_clear();
        do_reset();
        idle(2);
        check("idle_after_reset", actual(), 10'b0);

        // Back-to-back dependency: 3 stall cycles.
        do_reset();
        step(1, 2, 1, 3, 1, 1, 1, 0, 1);
        rs1 = 1; rs2 = 3; rs1_used = 1; rs2_used = 1; id_valid = 1; rd = 20; rd_wen = 1;
        hold_consumer(1, 3);
        check("cnt_d1", {6'b0, stall_cnt}, 10'd3);
        idle(4);

        // x0 never tracked; distance 4 gives no stall.
        step(1, 0, 0, 0, 0, 0, 1, 0, 1);
        step(1, 0, 1, 0, 1, 4, 1, 0, 1);
        step(1, 5, 0, 0, 0, 5, 1, 0, 1);
        idle(3);
        step(1, 5, 1, 5, 1, 6, 1, 0, 1);
        check("cnt_d4", {6'b0, stall_cnt}, 10'd3);
        idle(4);

        // Distance 2 then branch arriving mid-stall.
        step(1, 0, 0, 0, 0, 6, 1, 0, 1);
        idle(1);
        step(1, 6, 1, 0, 0, 7, 1, 0, 1);
        step(1, 6, 1, 0, 0, 7, 1, 1, 1);
        check("cnt_branch", {6'b0, stall_cnt}, 10'd4);
        idle(4);

        // Freeze for 4 cycles after the first stall cycle.
        do_reset();
        step(1, 0, 0, 0, 0, 7, 1, 0, 1);
        step(1, 7, 1, 0, 0, 8, 1, 0, 1);
        for (int i = 0; i < 4; i++) step(1, 7, 1, 0, 0, 8, 1, 0, 0);
        hold_consumer(7, 0);
        check("cnt_freeze", {6'b0, stall_cnt}, 10'd3);
        idle(4);

        // Asynchronous reset in the middle of a stall.
        step(1, 0, 0, 0, 0, 9, 1, 0, 1);
        step(1, 9, 1, 0, 0, 10, 1, 0, 1);
        check("mid_stall", actual(), expected());
        #2 rst_n = 1'b0;
        #1 check("async_reset", {raw_stall, 5'b0, stall_cnt}, 10'b0);
        model_clear();
        @(posedge clk); #1 rst_n = 1'b1;
        id_valid = 0;

        // Random traffic on a small register set to provoke hazards and saturation.
        for (int i = 0; i < 2000; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 1),
                 $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 7),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 4) != 0);
        end
        check("cnt_saturated", {6'b0, stall_cnt}, 10'(CMAX));

        @(posedge clk); @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
